input_mapper: RTL and testbench

- Parametrised successor of the existing MPU input-config stage: maps 12 physical controls onto the MPU K-input bus plus BETA/BA/ACL lines.
- Adds per-button synchronisation and debounce, N strobe lines with configurable K width, and an optional turbo (auto-fire) mode.
- Sits between the platform controller inputs and the SM5xx/SM510 core.
- The top level drives `strobe` from either the S shifter or the R outputs, so the block is CPU-agnostic.

---
 rtl/input_mapper.sv | 170 +++++++++++++++++
 tb/tb_input_mapper.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_mapper.sv
// input_mapper: maps 12 debounced controls onto the MPU K-input bus and the
// BETA/BA/ACL lines through per-strobe configuration bytes.
// Optional feature macro: INPUT_TURBO_EN (turbo/auto-fire codes 25-28).
module input_mapper #(
    parameter int STROBE_COUNT    = 8,
    parameter int K_WIDTH         = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TURBO_PERIOD    = 1024
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [11:0]                       buttons,
    input  logic [STROBE_COUNT-1:0]           strobe,
    input  logic [STROBE_COUNT*K_WIDTH*8-1:0] strobe_config,
    input  logic [23:0]                       aux_config,
    output logic [K_WIDTH-1:0]                input_k,
    output logic                              input_beta,
    output logic                              input_ba,
    output logic                              input_acl,
    output logic [11:0]                       buttons_clean
);

    localparam int SEL_W   = (STROBE_COUNT > 1) ? $clog2(STROBE_COUNT) : 1;
    localparam int ENTRY_W = K_WIDTH * 8;
    localparam int N_MAP   = K_WIDTH + 3;

    logic [11:0] sync1, sync2, clean;

    // Two-flop synchroniser for the asynchronous button inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= buttons;
            sync2 <= sync1;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_nodb
            assign clean = sync2;
        end else begin : g_db
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            logic [CW-1:0] cnt [12];
            logic [11:0]   clean_q;

            // Per-button debounce: accept a new level after DEBOUNCE_CYCLES differing samples
            always_ff @(posedge clk) begin
                for (int unsigned i = 0; i < 12; i++) begin
                    if (reset) begin
                        cnt[i]     <= '0;
                        clean_q[i] <= 1'b0;
                    end else if (sync2[i] == clean_q[i]) begin
                        cnt[i] <= '0;
                    end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                        clean_q[i] <= sync2[i];
                        cnt[i]     <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end
            end

            assign clean = clean_q;
        end
    endgenerate

`ifdef INPUT_TURBO_EN
    localparam int TW = (TURBO_PERIOD > 1) ? $clog2(TURBO_PERIOD) : 1;
    logic [TW-1:0] turbo_cnt;
    logic          turbo_phase;

    // Free-running turbo counter; phase flips each time the counter wraps
    always_ff @(posedge clk) begin
        if (reset) begin
            turbo_cnt   <= '0;
            turbo_phase <= 1'b0;
        end else if (turbo_cnt == TW'(TURBO_PERIOD - 1)) begin
            turbo_cnt   <= '0;
            turbo_phase <= ~turbo_phase;
        end else begin
            turbo_cnt <= turbo_cnt + 1'b1;
        end
    end
`endif

    logic [SEL_W-1:0] sel;
    logic             found;

    // Lowest-index active strobe selects the entry; none active falls back to entry 0
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < STROBE_COUNT; i++) begin
            if (strobe[i] && !found) begin
                sel   = SEL_W'(i);
                found = 1'b1;
            end
        end
    end

    logic [ENTRY_W-1:0]   entry;
    logic [N_MAP*8-1:0]   codes;
    logic [N_MAP-1:0]     mapped;

    assign entry = strobe_config[int'(sel)*ENTRY_W +: ENTRY_W];
    // K bytes occupy the low slots, followed by BETA, BA, ACL
    assign codes = {aux_config, entry};

    function automatic logic plain_src(input logic [6:0] code, input logic [11:0] b);
        case (code)
            7'd0,  7'd17: plain_src = b[0];
            7'd1,  7'd18: plain_src = b[1];
            7'd2,  7'd19: plain_src = b[2];
            7'd3,  7'd20: plain_src = b[3];
            7'd5,  7'd24: plain_src = b[4];
            7'd4,  7'd22: plain_src = b[5];
            7'd7,  7'd21: plain_src = b[6];
            7'd6,  7'd23: plain_src = b[7];
            7'd12:        plain_src = b[8];
            7'd16:        plain_src = b[9];
            7'd14:        plain_src = b[10];
            7'd13:        plain_src = b[11];
            default:      plain_src = 1'b0;
        endcase
    endfunction

    generate
        for (genvar m = 0; m < N_MAP; m++) begin : g_map
            logic [7:0] code;
            logic       src;
            assign code = codes[m*8 +: 8];

            // Resolve the source button for this slot (turbo gating before inversion)
            always_comb begin
                src = plain_src(code[6:0], clean);
`ifdef INPUT_TURBO_EN
                case (code[6:0])
                    7'd25:   src = clean[4] & turbo_phase;
                    7'd26:   src = clean[5] & turbo_phase;
                    7'd27:   src = clean[6] & turbo_phase;
                    7'd28:   src = clean[7] & turbo_phase;
                    default: ;
                endcase
`endif
            end

            assign mapped[m] = code[7] ^ src;
        end
    endgenerate

    // Output registers toward the MPU
    always_ff @(posedge clk) begin
        if (reset) begin
            input_k       <= '0;
            input_beta    <= 1'b0;
            input_ba      <= 1'b0;
            input_acl     <= 1'b0;
            buttons_clean <= '0;
        end else begin
            input_k       <= mapped[K_WIDTH-1:0];
            input_beta    <= mapped[K_WIDTH];
            input_ba      <= mapped[K_WIDTH+1];
            input_acl     <= mapped[K_WIDTH+2];
            buttons_clean <= clean;
        end
    end

endmodule

// File: tb/tb_input_mapper.sv
// Self-checking bench for input_mapper: directed literal checks plus a
// randomized run compared every cycle against a behavioural model.
// Honours INPUT_TURBO_EN the same way as the design.
module tb_input_mapper;

    localparam int SC = 8;
    localparam int KW = 4;
    localparam int DB = 4;
    localparam int TP = 8;
`ifdef INPUT_TURBO_EN
    localparam bit TURBO = 1'b1;
`else
    localparam bit TURBO = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [11:0]       buttons = '0;
    logic [SC-1:0]     strobe = '0;
    logic [SC*KW*8-1:0] strobe_config = '0;
    logic [23:0]       aux_config = 24'h7F7F7F;
    logic [KW-1:0]     input_k;
    logic              input_beta, input_ba, input_acl;
    logic [11:0]       buttons_clean;

    input_mapper #(
        .STROBE_COUNT(SC),
        .K_WIDTH(KW),
        .DEBOUNCE_CYCLES(DB),
        .TURBO_PERIOD(TP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .buttons(buttons),
        .strobe(strobe),
        .strobe_config(strobe_config),
        .aux_config(aux_config),
        .input_k(input_k),
        .input_beta(input_beta),
        .input_ba(input_ba),
        .input_acl(input_acl),
        .buttons_clean(buttons_clean)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Button index driven by each configuration code, straight from the code table
    function automatic logic model_bit(input logic [7:0] code, input logic [11:0] cl, input logic ph);
        int  c;
        logic s;
        c = int'(code[6:0]);
        s = 1'b0;
        if (c <= 3)                  s = cl[c];
        else if (c >= 17 && c <= 20) s = cl[c-17];
        else begin
            case (c)
                4:  s = cl[5];
                5:  s = cl[4];
                6:  s = cl[7];
                7:  s = cl[6];
                12: s = cl[8];
                13: s = cl[11];
                14: s = cl[10];
                16: s = cl[9];
                21: s = cl[6];
                22: s = cl[5];
                23: s = cl[7];
                24: s = cl[4];
                25: s = TURBO ? (cl[4] & ph) : 1'b0;
                26: s = TURBO ? (cl[5] & ph) : 1'b0;
                27: s = TURBO ? (cl[6] & ph) : 1'b0;
                28: s = TURBO ? (cl[7] & ph) : 1'b0;
                default: s = 1'b0;
            endcase
        end
        return s ^ code[7];
    endfunction

    // Model state: two-sample delay line, debounced level, window of presented samples
    logic [11:0] m_s1, m_s2, m_clean;
    logic [11:0] m_hist[$];
    int          m_n;
    bit          m_valid = 1'b0;
    logic [KW-1:0] e_k;
    logic        e_beta, e_ba, e_acl;
    logic [11:0] e_bc;

    // Behavioural model advanced on each rising edge from the pre-edge inputs
    always @(posedge clk) begin
        int   sel;
        logic ph;
        logic all_diff;
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_clean = '0;
            m_hist.delete();
            m_n = 0;
            e_k = '0; e_beta = 1'b0; e_ba = 1'b0; e_acl = 1'b0; e_bc = '0;
            m_valid = 1'b1;
        end else begin
            ph = ((m_n / TP) % 2) == 1;
            sel = -1;
            for (int i = 0; i < SC; i++)
                if (strobe[i] && sel < 0) sel = i;
            if (sel < 0) sel = 0;
            for (int k = 0; k < KW; k++)
                e_k[k] = model_bit(strobe_config[(sel*KW+k)*8 +: 8], m_clean, ph);
            e_beta = model_bit(aux_config[7:0],   m_clean, ph);
            e_ba   = model_bit(aux_config[15:8],  m_clean, ph);
            e_acl  = model_bit(aux_config[23:16], m_clean, ph);
            e_bc   = m_clean;
            // A level is accepted once the last DB presented samples all disagree with it
            m_hist.push_back(m_s2);
            if (m_hist.size() > DB) void'(m_hist.pop_front());
            if (m_hist.size() == DB) begin
                for (int b = 0; b < 12; b++) begin
                    all_diff = 1'b1;
                    foreach (m_hist[j]) if (m_hist[j][b] == m_clean[b]) all_diff = 1'b0;
                    if (all_diff) m_clean[b] = ~m_clean[b];
                end
            end
            m_s2 = m_s1;
            m_s1 = buttons;
            m_n++;
        end
    end

    // Compare every output against the model on each falling edge
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_k",    32'(input_k),       32'(e_k));
            check("model_beta", 32'(input_beta),    32'(e_beta));
            check("model_ba",   32'(input_ba),      32'(e_ba));
            check("model_acl",  32'(input_acl),     32'(e_acl));
            check("model_bc",   32'(buttons_clean), 32'(e_bc));
        end
    end

    task automatic set_cfg(input int s, input int k, input logic [7:0] v);
        strobe_config[(s*KW+k)*8 +: 8] = v;
    endtask

    initial begin
        int last_chg, n_chg;
        logic prev;
        logic [7:0] rb;

        // Reset with all buttons pressed
        buttons = 12'hFFF;
        aux_config = {8'h05, 8'h7F, 8'h8E};
        reset = 1'b1;
        @(negedge clk);
        tick(5);
        check("rst_k",    32'(input_k),       32'h0);
        check("rst_beta", 32'(input_beta),    32'h0);
        check("rst_acl",  32'(input_acl),     32'h0);
        check("rst_bc",   32'(buttons_clean), 32'h0);
        reset = 1'b0;
        tick(1);
        check("beta_idle_edge1", 32'(input_beta), 32'h1);
        tick(5);
        check("bc_edge6", 32'(buttons_clean), 32'h000);
        tick(1);
        check("bc_edge7",   32'(buttons_clean), 32'hFFF);
        check("beta_start", 32'(input_beta),    32'h0);
        check("acl_a",      32'(input_acl),     32'h1);

        buttons = '0;
        tick(10);

        // Entry 2 bit0 maps a, selected by strobe bit 2
        set_cfg(2, 0, 8'h05);
        set_cfg(2, 1, 8'h04);
        strobe = 8'h04;
        tick(2);
        check("a_idle", 32'(input_k[0]), 32'h0);
        buttons[4] = 1'b1;
        tick(6);
        check("a_edge6", 32'(input_k[0]), 32'h0);
        tick(1);
        check("a_edge7", 32'(input_k[0]), 32'h1);
        set_cfg(0, 0, 8'h85);
        strobe = 8'h00;
        tick(1);
        check("strobe0_inv_a", 32'(input_k[0]), 32'h0);
        buttons[4] = 1'b0;
        strobe = 8'h04;
        tick(8);

        // Short b glitch must be filtered
        buttons[5] = 1'b1;
        tick(DB - 1);
        buttons[5] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("glitch_bc5", 32'(buttons_clean[5]), 32'h0);
            check("glitch_k1",  32'(input_k[1]),       32'h0);
        end
        buttons[5] = 1'b1;
        tick(6);
        check("hold_b_edge6", 32'(buttons_clean[5]), 32'h0);
        tick(1);
        check("hold_b_edge7", 32'(buttons_clean[5]), 32'h1);
        check("hold_b_k1",    32'(input_k[1]),       32'h1);
        buttons[5] = 1'b0;
        tick(8);

        // Lowest strobe bit wins; inverted, constant and unhandled codes
        set_cfg(1, 0, 8'h85);
        set_cfg(1, 1, 8'h7F);
        set_cfg(1, 2, 8'h0A);
        set_cfg(1, 3, 8'h05);
        for (int k = 0; k < KW; k++) set_cfg(3, k, 8'h80);
        strobe = 8'h0A;
        tick(1);
        check("lowest_strobe", 32'(input_k), 32'h1);

        // BETA = inverted start
        buttons[10] = 1'b1;
        tick(7);
        check("beta_start_held", 32'(input_beta), 32'h0);
        buttons[10] = 1'b0;
        tick(7);
        check("beta_start_rel", 32'(input_beta), 32'h1);

        // Turbo a on entry 0 bit 0
        set_cfg(0, 0, 8'h19);
        strobe = 8'h00;
        buttons[4] = 1'b1;
        tick(8);
        prev = input_k[0];
        last_chg = -1;
        n_chg = 0;
        for (int i = 0; i < 48; i++) begin
            tick(1);
            if (TURBO) begin
                if (input_k[0] !== prev) begin
                    if (last_chg >= 0) check("turbo_interval", 32'(i - last_chg), 32'(TP));
                    last_chg = i;
                    n_chg++;
                end
            end else begin
                check("turbo_off_zero", 32'(input_k[0]), 32'h0);
            end
            prev = input_k[0];
        end
        if (TURBO) check("turbo_toggles", 32'(n_chg >= 5), 32'h1);
        buttons[4] = 1'b0;
        tick(8);

        // Randomized run against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 7) == 0)
                buttons = buttons ^ (12'(1) << $urandom_range(0, 11));
            if ($urandom_range(0, 49) == 0)
                strobe = ($urandom_range(0, 3) == 0) ? '0 : SC'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 3))
                    0:       rb = 8'($urandom_range(0, 28));
                    1:       rb = 8'h7F;
                    2:       rb = 8'($urandom_range(25, 28));
                    default: rb = 8'($urandom);
                endcase
                rb[7] = 1'($urandom);
                if ($urandom_range(0, 4) == 0)
                    aux_config[$urandom_range(0, 2)*8 +: 8] = rb;
                else
                    strobe_config[$urandom_range(0, SC*KW-1)*8 +: 8] = rb;
            end
            reset = ($urandom_range(0, 599) == 0);
            tick(1);
        end
        reset = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
